// File: rtl/muldiv_pkg.sv
// Shared encodings for the EX-stage multiply/divide unit: Op codes, FSM states
// and the iteration counter width helper.
package muldiv_pkg;

    typedef enum logic [2:0] {
        OP_MULT  = 3'd0,
        OP_MULTU = 3'd1,
        OP_DIV   = 3'd2,
        OP_DIVU  = 3'd3,
        OP_MTHI  = 3'd4,
        OP_MTLO  = 3'd5
    } op_e;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_MUL,
        ST_DIV,
        ST_FIN
    } state_e;

    function automatic int cnt_width(input int data_width);
        return $clog2(data_width);
    endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Request/response bundle between the EX stage (master) and the multiply/divide unit (slave).
interface ex_muldiv_unit_if #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 3
);
    logic                  Start;
    logic [OP_WIDTH-1:0]   Op;
    logic [DATA_WIDTH-1:0] OperandA;
    logic [DATA_WIDTH-1:0] OperandB;
    logic                  Flush;
    logic                  ReadHiLo;
    logic                  Busy;
    logic                  Done;
    logic                  Stall;
    logic [DATA_WIDTH-1:0] HiOut;
    logic [DATA_WIDTH-1:0] LoOut;

    modport master (
        output Start, Op, OperandA, OperandB, Flush, ReadHiLo,
        input  Busy, Done, Stall, HiOut, LoOut
    );

    modport slave (
        input  Start, Op, OperandA, OperandB, Flush, ReadHiLo,
        output Busy, Done, Stall, HiOut, LoOut
    );
endinterface

// File: rtl/restoring_divider.sv
// Restoring divider on unsigned magnitudes: one quotient bit per step, stepped by the
// owning FSM, which also holds the shared iteration counter.
module restoring_divider #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  Clock,
    input  logic                  load,
    input  logic                  step,
    input  logic [DATA_WIDTH-1:0] dividend,
    input  logic [DATA_WIDTH-1:0] divisor,
    output logic [DATA_WIDTH-1:0] quotient,
    output logic [DATA_WIDTH-1:0] remainder
);
    localparam int W = DATA_WIDTH;

    logic [W-1:0] quo_q, quo_d, rem_q, rem_d, dvsr_q, dvsr_d;
    logic [W:0]   partial, diff;

    always_comb begin
        quo_d   = quo_q;
        rem_d   = rem_q;
        dvsr_d  = dvsr_q;
        partial = {rem_q, quo_q[W-1]};
        diff    = partial - {1'b0, dvsr_q};
        if (load) begin
            quo_d  = dividend;
            rem_d  = '0;
            dvsr_d = divisor;
        end else if (step) begin
            // A clear borrow bit means the divisor fits: keep the difference, shift in a 1.
            if (!diff[W]) begin
                rem_d = diff[W-1:0];
                quo_d = {quo_q[W-2:0], 1'b1};
            end else begin
                rem_d = partial[W-1:0];
                quo_d = {quo_q[W-2:0], 1'b0};
            end
        end
    end

    always_ff @(posedge Clock) begin
        quo_q  <= quo_d;
        rem_q  <= rem_d;
        dvsr_q <= dvsr_d;
    end

    assign quotient  = quo_q;
    assign remainder = rem_q;
endmodule

// File: rtl/ex_muldiv_unit.sv
// Iterative multiply/divide unit with architectural HI/LO registers for the EX stage.
// Define MULDIV_DIV_EN to build the divider; otherwise DIV/DIVU are ignored like reserved ops.
module ex_muldiv_unit #(
    parameter int DATA_WIDTH = 32,
    parameter int OP_WIDTH   = 3
) (
    input logic             Clock,
    input logic             Reset,
    ex_muldiv_unit_if.slave bus
);
    import muldiv_pkg::*;

    localparam int             W    = DATA_WIDTH;
    localparam int             CW   = cnt_width(DATA_WIDTH);
    localparam logic [CW-1:0]  LAST = CW'(DATA_WIDTH - 1);

    state_e         state_q, state_d;
    logic [CW-1:0]  count_q, count_d;
    logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;
    logic           busy_q, busy_d, done_q, done_d;

    logic [2*W-1:0] prod_q, prod_d;
    logic [W-1:0]   mcand_q, mcand_d;
    logic           neg_q, neg_d;
    logic [W:0]     mul_sum;
    logic [2*W-1:0] mul_res, fin_res;

    logic           is_mul, is_div, is_mthi, is_mtlo, is_signed, launch;
    logic [W-1:0]   a_mag, b_mag;

    always_comb begin
        is_mul    = (bus.Op == OP_WIDTH'(OP_MULT)) || (bus.Op == OP_WIDTH'(OP_MULTU));
        is_mthi   = (bus.Op == OP_WIDTH'(OP_MTHI));
        is_mtlo   = (bus.Op == OP_WIDTH'(OP_MTLO));
        is_signed = (bus.Op == OP_WIDTH'(OP_MULT)) || (bus.Op == OP_WIDTH'(OP_DIV));
`ifdef MULDIV_DIV_EN
        is_div    = (bus.Op == OP_WIDTH'(OP_DIV)) || (bus.Op == OP_WIDTH'(OP_DIVU));
`else
        is_div    = 1'b0;
`endif
        launch    = bus.Start && !bus.Flush && (state_q == ST_IDLE);
        a_mag     = (is_signed && bus.OperandA[W-1]) ? -bus.OperandA : bus.OperandA;
        b_mag     = (is_signed && bus.OperandB[W-1]) ? -bus.OperandB : bus.OperandB;
    end

    // Shift-add datapath: add the multiplicand into the upper half, then shift right.
    always_comb begin
        prod_d  = prod_q;
        mcand_d = mcand_q;
        neg_d   = neg_q;
        mul_sum = {1'b0, prod_q[2*W-1:W]} + {1'b0, (prod_q[0] ? mcand_q : {W{1'b0}})};
        if (launch && (is_mul || is_div)) begin
            neg_d = is_signed && (bus.OperandA[W-1] ^ bus.OperandB[W-1]);
        end
        if (launch && is_mul) begin
            mcand_d = a_mag;
            prod_d  = {{W{1'b0}}, b_mag};
        end else if (state_q == ST_MUL) begin
            prod_d  = {mul_sum, prod_q[W-1:1]};
        end
    end

    assign mul_res = neg_q ? -prod_q : prod_q;

`ifdef MULDIV_DIV_EN
    logic [W-1:0] quo, rem, a_q, a_d, div_hi, div_lo;
    logic         div_op_q, div_op_d, rem_neg_q, rem_neg_d, div_zero_q, div_zero_d;

    restoring_divider #(.DATA_WIDTH(W)) u_div (
        .Clock     (Clock),
        .load      (launch && is_div),
        .step      (state_q == ST_DIV),
        .dividend  (a_mag),
        .divisor   (b_mag),
        .quotient  (quo),
        .remainder (rem)
    );

    always_comb begin
        a_d        = a_q;
        div_op_d   = div_op_q;
        rem_neg_d  = rem_neg_q;
        div_zero_d = div_zero_q;
        if (launch && (is_mul || is_div)) begin
            a_d        = bus.OperandA;
            div_op_d   = is_div;
            rem_neg_d  = is_signed && bus.OperandA[W-1];
            div_zero_d = (bus.OperandB == '0);
        end
        // Divide by zero bypasses the sign fix-up: LO all ones, HI the raw dividend.
        if (div_zero_q) begin
            div_lo = '1;
            div_hi = a_q;
        end else begin
            div_lo = neg_q ? -quo : quo;
            div_hi = rem_neg_q ? -rem : rem;
        end
    end

    always_ff @(posedge Clock) begin
        a_q        <= a_d;
        div_op_q   <= div_op_d;
        rem_neg_q  <= rem_neg_d;
        div_zero_q <= div_zero_d;
    end

    assign fin_res = div_op_q ? {div_hi, div_lo} : mul_res;
`else
    assign fin_res = mul_res;
`endif

    // NOTE: every always_comb output gets a default first, otherwise paths that skip an assignment infer latches.
    always_comb begin
        state_d = state_q;
        count_d = count_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        done_d  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (launch) begin
                    count_d = '0;
                    if (is_mul)       state_d = ST_MUL;
                    else if (is_div)  state_d = ST_DIV;
                    else if (is_mthi) hi_d    = bus.OperandA;
                    else if (is_mtlo) lo_d    = bus.OperandA;
                end
            end
            ST_MUL, ST_DIV: begin
                count_d = count_q + CW'(1);
                if (count_q == LAST) state_d = ST_FIN;
            end
            ST_FIN: begin
                state_d      = ST_IDLE;
                done_d       = 1'b1;
                {hi_d, lo_d} = fin_res;
            end
        endcase
        if (bus.Flush) begin
            state_d = ST_IDLE;
            hi_d    = hi_q;
            lo_d    = lo_q;
            done_d  = 1'b0;
        end
        // Busy rises one edge after launch and drops on the edge that raises Done.
        busy_d = (state_q != ST_IDLE) && (state_d != ST_IDLE);
    end

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            count_q <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            count_q <= count_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // NOTE: datapath registers are reloaded on every launch, so they carry no reset.
    always_ff @(posedge Clock) begin
        prod_q  <= prod_d;
        mcand_q <= mcand_d;
        neg_q   <= neg_d;
    end

    assign bus.Busy  = busy_q;
    assign bus.Done  = done_q;
    assign bus.Stall = busy_q & bus.ReadHiLo;
    assign bus.HiOut = hi_q;
    assign bus.LoOut = lo_q;
endmodule
